countdown_bcd_timer: RTL and testbench

BCD countdown timer, the down-counting counterpart of the free-running time-of-day counter. It holds six BCD digits in the same ss:mm:hh layout: units 0-9, tens 0-5, alternating. The digits are loaded, started and paused under control. On each Tick the value decrements with borrow, and Done pulses on expiry. It sits between the 1 Hz tick prescaler and the display/alarm logic.

---
 rtl/countdown_bcd_timer.sv | 150 +++++++++++++++
 tb/tb_countdown_bcd_timer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/countdown_bcd_timer.sv
// Six-digit BCD countdown timer (ss:mm:hh layout) with load/start/stop control and a Done pulse on expiry.
// Optional build macro AUTO_RELOAD_EN: on expiry, reload the last loaded value and keep running.
module countdown_bcd_timer #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             Tick,
  input  logic             Load,
  input  logic             Start,
  input  logic             Stop,
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  input  logic [WIDTH-1:0] D3,
  input  logic [WIDTH-1:0] D4,
  input  logic [WIDTH-1:0] D5,
  output logic [WIDTH-1:0] Q0,
  output logic [WIDTH-1:0] Q1,
  output logic [WIDTH-1:0] Q2,
  output logic [WIDTH-1:0] Q3,
  output logic [WIDTH-1:0] Q4,
  output logic [WIDTH-1:0] Q5,
  output logic             Running,
  output logic             Zero,
  output logic             Done
);

  // state   | meaning
  // IDLE    | loaded or reset, not counting
  // RUN     | decrementing on each Tick
  // PAUSE   | stopped mid-count, Start resumes
  // EXPIRED | reached zero, only Load or Clr leaves
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

  state_t           state;
  logic [WIDTH-1:0] q    [6];
  logic [WIDTH-1:0] din  [6];
  logic [WIDTH-1:0] dsat [6];
  logic [WIDTH-1:0] dec  [6];
  logic             is_one;
`ifdef AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload [6];
`endif

  function automatic logic [WIDTH-1:0] lim(input int i);
    return ((i % 2) != 0) ? WIDTH'(5) : WIDTH'(9);
  endfunction

  assign din[0] = D0;
  assign din[1] = D1;
  assign din[2] = D2;
  assign din[3] = D3;
  assign din[4] = D4;
  assign din[5] = D5;

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      dsat[i] = (din[i] > lim(i)) ? lim(i) : din[i];
    end
  end

  // Borrow ripples from seconds units upward within one cycle.
  always_comb begin : dec_blk
    logic borrow;
    borrow = 1'b1;
    for (int i = 0; i < 6; i++) begin
      dec[i] = q[i];
      if (borrow) begin
        if (q[i] == '0) begin
          dec[i] = lim(i);
        end else begin
          dec[i] = q[i] - WIDTH'(1);
          borrow = 1'b0;
        end
      end
    end
  end

  assign is_one = (q[0] == WIDTH'(1)) && (q[1] == '0) && (q[2] == '0) &&
                  (q[3] == '0) && (q[4] == '0) && (q[5] == '0);
  assign Zero   = (q[0] == '0) && (q[1] == '0) && (q[2] == '0) &&
                  (q[3] == '0) && (q[4] == '0) && (q[5] == '0);

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state   <= IDLE;
      Running <= 1'b0;
      Done    <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        q[i] <= '0;
`ifdef AUTO_RELOAD_EN
        reload[i] <= '0;
`endif
      end
    end else begin
      Done <= 1'b0;
      if (Load) begin
        state   <= IDLE;
        Running <= 1'b0;
        for (int i = 0; i < 6; i++) begin
          q[i] <= dsat[i];
`ifdef AUTO_RELOAD_EN
          reload[i] <= dsat[i];
`endif
        end
      end else begin
        case (state)
          IDLE, PAUSE: begin
            if (Start && !Zero) begin
              state   <= RUN;
              Running <= 1'b1;
            end
          end
          RUN: begin
            if (Stop) begin
              state   <= PAUSE;
              Running <= 1'b0;
            end else if (Tick) begin
              if (is_one) begin
                Done <= 1'b1;
`ifdef AUTO_RELOAD_EN
                for (int i = 0; i < 6; i++) q[i] <= reload[i];
`else
                for (int i = 0; i < 6; i++) q[i] <= '0;
                state   <= EXPIRED;
                Running <= 1'b0;
`endif
              end else begin
                for (int i = 0; i < 6; i++) q[i] <= dec[i];
              end
            end
          end
          default: begin
            state   <= EXPIRED;
            Running <= 1'b0;
          end
        endcase
      end
    end
  end

  assign Q0 = q[0];
  assign Q1 = q[1];
  assign Q2 = q[2];
  assign Q3 = q[3];
  assign Q4 = q[4];
  assign Q5 = q[5];

endmodule

// File: tb/tb_countdown_bcd_timer.sv
// Directed bench for countdown_bcd_timer: reset, borrow chains, expiry, pause/priority, saturation, async reset.
module tb_countdown_bcd_timer;

  logic       Clk, Clr, Tick, Load, Start, Stop;
  logic [3:0] d0, d1, d2, d3, d4, d5;
  logic [3:0] q0, q1, q2, q3, q4, q5;
  logic       Running, Zero, Done;
  int         checks = 0;
  int         errors = 0;

  countdown_bcd_timer #(.WIDTH(4)) dut (
    .Clk(Clk), .Clr(Clr), .Tick(Tick), .Load(Load), .Start(Start), .Stop(Stop),
    .D0(d0), .D1(d1), .D2(d2), .D3(d3), .D4(d4), .D5(d5),
    .Q0(q0), .Q1(q1), .Q2(q2), .Q3(q3), .Q4(q4), .Q5(q5),
    .Running(Running), .Zero(Zero), .Done(Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [23:0] qall();
    return {q5, q4, q3, q2, q1, q0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setd(input logic [23:0] v);
    {d5, d4, d3, d2, d1, d0} = v;
  endtask

  // Drive controls for one rising edge, then sample 1 time unit after it.
  task automatic pulse(input logic ld, input logic st, input logic sp, input logic tk);
    Load = ld; Start = st; Stop = sp; Tick = tk;
    @(posedge Clk);
    #1;
    Load = 1'b0; Start = 1'b0; Stop = 1'b0; Tick = 1'b0;
  endtask

  initial begin
    Clr = 1'b0; Tick = 1'b0; Load = 1'b0; Start = 1'b0; Stop = 1'b0;
    setd(24'h000000);
    #12;
    chk("rst_q", qall(), 24'h000000);
    chk("rst_zero", Zero, 1'b1);
    chk("rst_run", Running, 1'b0);
    chk("rst_done", Done, 1'b0);
    Clr = 1'b1;

    for (int i = 0; i < 4; i++) begin
      pulse(1'b0, 1'b0, 1'b0, i[0]);
      chk("hold_q", qall(), 24'h000000);
      chk("hold_done", Done, 1'b0);
      chk("hold_run", Running, 1'b0);
    end

    setd(24'h000010);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    chk("ld10_q", qall(), 24'h000010);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    chk("ld10_run", Running, 1'b1);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    chk("borrow1", qall(), 24'h000009);

    setd(24'h000100);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    chk("borrow2", qall(), 24'h000059);
    Tick = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Tick = 1'b0;
    chk("tick_held", qall(), 24'h000057);

    setd(24'h100000);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    chk("borrow5", qall(), 24'h095959);

`ifndef AUTO_RELOAD_EN
    setd(24'h000003);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    chk("exp_pre_q", qall(), 24'h000001);
    chk("exp_pre_done", Done, 1'b0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    chk("exp_q", qall(), 24'h000000);
    chk("exp_done", Done, 1'b1);
    chk("exp_run", Running, 1'b0);
    chk("exp_zero", Zero, 1'b1);
    pulse(1'b0, 1'b0, 1'b0, 1'b0);
    chk("exp_done_once", Done, 1'b0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    chk("exp_hold_q", qall(), 24'h000000);
    chk("exp_hold_done", Done, 1'b0);
    chk("exp_hold_run", Running, 1'b0);
`else
    setd(24'h000002);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ar_t1_q", qall(), 24'h000001);
    chk("ar_t1_done", Done, 1'b0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ar_t2_q", qall(), 24'h000002);
    chk("ar_t2_done", Done, 1'b1);
    chk("ar_t2_run", Running, 1'b1);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ar_t3_q", qall(), 24'h000001);
    chk("ar_t3_done", Done, 1'b0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ar_t4_q", qall(), 24'h000002);
    chk("ar_t4_done", Done, 1'b1);
    chk("ar_t4_run", Running, 1'b1);
`endif

    setd(24'h000005);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    chk("pause_t1", qall(), 24'h000004);
    pulse(1'b0, 1'b0, 1'b1, 1'b1);
    chk("pause_q", qall(), 24'h000004);
    chk("pause_run", Running, 1'b0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    chk("pause_tick_q", qall(), 24'h000004);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    chk("resume_run", Running, 1'b1);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    chk("resume_q", qall(), 24'h000003);
    setd(24'h00007F);
    pulse(1'b1, 1'b0, 1'b0, 1'b1);
    chk("sat_q", qall(), 24'h000059);
    chk("sat_run", Running, 1'b0);

    setd(24'h000000);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    chk("zstart_run", Running, 1'b0);
    chk("zstart_done", Done, 1'b0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    chk("zstart_q", qall(), 24'h000000);

    setd(24'h000002);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    chk("arst_pre_run", Running, 1'b1);
    #2;
    Clr = 1'b0;
    #1;
    chk("arst_q", qall(), 24'h000000);
    chk("arst_run", Running, 1'b0);
    chk("arst_zero", Zero, 1'b1);
    Clr = 1'b1;
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    chk("arst_idle_q", qall(), 24'h000000);
    chk("arst_idle_run", Running, 1'b0);
    chk("arst_done", Done, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
